// File: rtl/sramlike_axi_pkg.sv
// Shared definitions for the sram-like to AXI3 bridge.
//   BURST_INCR / LEN_SINGLE : fixed AXI burst fields (single-beat INCR)
//   rd_state_e / wr_state_e : read (R_IDLE/R_AR/R_R) and write (W_IDLE/W_AW/W_B) FSM states
//   size_to_wstrb           : byte-lane strobe from transfer size and address low bits
package sramlike_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

  // Size 3 is not a legal sram-like size; it is handled as a full word.
  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 4'b0001 << addr_lo;
      2'd1:    return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   cand     : candidate vector
//   advance  : a grant is being taken; pointer moves past the granted index
//   grant    : one-hot grant (all zero when no candidate)
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cand,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps; the first candidate found wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    ptr_d = ptr_q;
    idx   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && cand[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sramlike_axi_mux.sv
// Bridge from NPORT sram-like master ports onto one AXI3 master.
//   clk, rst        : clock, asynchronous active-high reset
//   port_*          : per-port sram-like request (req/wr/size/addr/wdata) and
//                     response (addr_ok/data_ok, shared rdata)
//   ar*/r*/aw*/w*/b*: AXI3 master; one read and one write in flight, ID = port index
module sramlike_axi_mux
  import sramlike_axi_pkg::*;
#(
  parameter int unsigned NPORT = 2,
  parameter int unsigned ID_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    port_req,
  input  logic [NPORT-1:0]    port_wr,
  input  logic [2*NPORT-1:0]  port_size,
  input  logic [32*NPORT-1:0] port_addr,
  input  logic [32*NPORT-1:0] port_wdata,
  output logic [NPORT-1:0]    port_addr_ok,
  output logic [NPORT-1:0]    port_data_ok,
  output logic [31:0]         port_rdata,
  output logic [ID_W-1:0]     arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  rd_state_e          r_state_q, r_state_d;
  wr_state_e          w_state_q, w_state_d;
  logic [NPORT-1:0]   busy_q, busy_d;
  logic [NPORT-1:0]   hazard, rd_cand, wr_cand, rd_gnt, wr_gnt;
  logic               rd_open, wr_open, rd_fin, wr_fin, aw_ok, w_ok;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0]        ar_addr_q, aw_addr_q, w_data_q;
  logic [1:0]         ar_size_q, aw_size_q;
  logic [3:0]         w_strb_q;
  logic [ID_W-1:0]    ar_id_q, aw_id_q;
  logic [ID_W-1:0]    rd_idx, wr_idx;
  logic [31:0]        rd_addr_sel, wr_addr_sel, wr_data_sel;
  logic [1:0]         rd_size_sel, wr_size_sel;
  logic               unused_resp;

  assign unused_resp = ^{rresp, rlast, bresp};

  // A read to the word of the in-flight write waits until that write is done.
  always_comb begin
    hazard = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      hazard[i] = (w_state_q != W_IDLE) && (port_addr[32*i+2 +: 30] == aw_addr_q[31:2]);
    end
  end

  // Grants are held off while rst is high so addr_ok stays low in reset.
  assign rd_open = (r_state_q == R_IDLE) && !rst;
  assign wr_open = (w_state_q == W_IDLE) && !rst;
  assign rd_cand = rd_open ? (port_req & ~port_wr & ~busy_q & ~hazard) : '0;
  assign wr_cand = wr_open ? (port_req & port_wr & ~busy_q) : '0;

  rr_arbiter #(.N(NPORT)) u_rd_arb (
    .clk(clk), .rst(rst), .cand(rd_cand), .advance(|rd_cand), .grant(rd_gnt)
  );

  rr_arbiter #(.N(NPORT)) u_wr_arb (
    .clk(clk), .rst(rst), .cand(wr_cand), .advance(|wr_cand), .grant(wr_gnt)
  );

  always_comb begin
    rd_idx      = '0;
    rd_addr_sel = '0;
    rd_size_sel = '0;
    wr_idx      = '0;
    wr_addr_sel = '0;
    wr_data_sel = '0;
    wr_size_sel = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (rd_gnt[i]) begin
        rd_idx      = ID_W'(i);
        rd_addr_sel = port_addr[32*i +: 32];
        rd_size_sel = port_size[2*i +: 2];
      end
      if (wr_gnt[i]) begin
        wr_idx      = ID_W'(i);
        wr_addr_sel = port_addr[32*i +: 32];
        wr_data_sel = port_wdata[32*i +: 32];
        wr_size_sel = port_size[2*i +: 2];
      end
    end
  end

  assign rd_fin = (r_state_q == R_R) && rvalid;
  assign wr_fin = (w_state_q == W_B) && bvalid;
  assign aw_ok  = aw_done_q || awready;
  assign w_ok   = w_done_q || wready;

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (|rd_gnt) r_state_d = R_AR;
      R_AR:    if (arready) r_state_d = R_R;
      R_R:     if (rvalid) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // AW and W handshakes may complete in either order; each is remembered
  // until both have happened.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    case (w_state_q)
      W_IDLE:  if (|wr_gnt) w_state_d = W_AW;
      W_AW: begin
        if (aw_ok && w_ok) begin
          w_state_d = W_B;
        end else begin
          aw_done_d = aw_ok;
          w_done_d  = w_ok;
        end
      end
      W_B:     if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    port_data_ok = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      port_data_ok[i] = (rd_fin && (rid == ID_W'(i))) || (wr_fin && (bid == ID_W'(i)));
    end
  end

  assign port_addr_ok = rd_gnt | wr_gnt;
  assign busy_d       = (busy_q | port_addr_ok) & ~port_data_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      busy_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_size_q <= '0;
      ar_id_q   <= '0;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      aw_id_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      busy_q    <= busy_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (|rd_gnt) begin
        ar_addr_q <= rd_addr_sel;
        ar_size_q <= rd_size_sel;
        ar_id_q   <= rd_idx;
      end
      if (|wr_gnt) begin
        aw_addr_q <= wr_addr_sel;
        aw_size_q <= wr_size_sel;
        aw_id_q   <= wr_idx;
        w_data_q  <= wr_data_sel;
        w_strb_q  <= size_to_wstrb(wr_size_sel, wr_addr_sel[1:0]);
      end
    end
  end

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_R);

  assign awid    = aw_id_q;
  assign awaddr  = aw_addr_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, aw_size_q};
  assign awburst = BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = (w_state_q == W_AW) && !aw_done_q;
  assign wid     = aw_id_q;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state_q == W_AW) && !w_done_q;
  assign bready  = (w_state_q == W_B);

  assign port_rdata = rdata;

endmodule
